// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch types: next-PC select encoding, fetch FSM states, reset constants
package riscv_pkg;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_t;

   typedef enum logic [1:0] {
      S_REQ  = 2'b00,
      S_WAIT = 2'b01,
      S_HOLD = 2'b10
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// rtl/fetch_sequencer_next_pc_mux.sv - next-PC select: pc+4, branch target or jump target
module fetch_sequencer_next_pc_mux
   import riscv_pkg::*;
(
   input  pc_src_t     pc_src,
   input  logic [31:0] pc,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic [31:0] next_pc
);

   // pc+4 wraps naturally at 2^32
   always_comb begin
      next_pc = pc + 32'd4;
      case (pc_src)
         PC_BRANCH: next_pc = branch_target;
         PC_JUMP:   next_pc = jump_target;
         default:   next_pc = pc + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller; optional MISALIGN_TRAP_EN traps misaligned redirects
module fetch_sequencer
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
   parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump_valid,
   input  logic [31:0] jump_target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [1:0]  pc_src,
   output logic        misalign_fault
);

   fetch_state_t state;
   pc_src_t      sel;
   logic [31:0]  pc;
   logic [31:0]  mux_pc;
   logic [31:0]  pc_next;
   logic         redirect;
   logic         advance;
   logic         squash;
   logic         req_fire;

   assign redirect       = jump_valid | branch_taken;
   assign advance        = (state == S_HOLD) && inst_valid && inst_ready;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign imem_addr      = pc;
   assign pc_src         = sel;

   // jump beats branch when both arrive together; select is 00 whenever no redirect
   always_comb begin
      sel = PC_PLUS4;
      if (jump_valid)
         sel = PC_JUMP;
      else if (branch_taken)
         sel = PC_BRANCH;
   end

   fetch_sequencer_next_pc_mux u_next_pc_mux (
      .pc_src        (sel),
      .pc            (pc),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .next_pc       (mux_pc)
   );

`ifdef MISALIGN_TRAP_EN
   logic misaligned;
   logic fault_q;

   assign misaligned     = redirect && (mux_pc[1:0] != 2'b00);
   assign pc_next        = misaligned ? TRAP_VECTOR : mux_pc;
   assign misalign_fault = fault_q;

   // one-cycle fault pulse following a misaligned redirect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fault_q <= 1'b0;
      else
         fault_q <= misaligned;
   end
`else
   logic unused_trap_vector;

   assign unused_trap_vector = ^TRAP_VECTOR;
   assign pc_next        = redirect ? {mux_pc[31:2], 2'b00} : mux_pc;
   assign misalign_fault = 1'b0;
`endif

   // fetch FSM: one outstanding request; a request already accepted when a redirect hits is squashed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_REQ;
         pc             <= RESET_PC;
         imem_req_valid <= 1'b0;
         squash         <= 1'b0;
         inst_valid     <= 1'b0;
         inst_data      <= 32'h0;
         inst_pc        <= 32'h0;
      end else begin
         if (redirect || advance)
            pc <= pc_next;
         case (state)
            S_REQ: begin
               if (req_fire) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
                  squash         <= redirect;
               end else begin
                  imem_req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (redirect || squash) begin
                     squash         <= 1'b0;
                     state          <= S_REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     inst_valid <= 1'b1;
                     inst_data  <= imem_rsp_data;
                     inst_pc    <= pc;
                     state      <= S_HOLD;
                  end
               end else if (redirect) begin
                  squash <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect || advance) begin
                  inst_valid     <= 1'b0;
                  state          <= S_REQ;
                  imem_req_valid <= 1'b1;
               end
            end
            default: begin
               state          <= S_REQ;
               imem_req_valid <= 1'b0;
               squash         <= 1'b0;
               inst_valid     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector bench for fetch_sequencer
module tb_fetch_sequencer;

`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] EXP_MIS = 32'h0000_0100;
   localparam logic        EXP_FLT = 1'b1;
`else
   localparam logic [31:0] EXP_MIS = 32'h0000_0040;
   localparam logic        EXP_FLT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [1:0]  pc_src;
   logic        misalign_fault;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        bt;
      logic [31:0] btgt;
      logic        jv;
      logic [31:0] jtgt;
      logic        rdy;
      logic        rspv;
      logic [31:0] rspd;
      logic        ir;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_idata;
      logic [31:0] e_ipc;
      logic [1:0]  e_src;
      logic        e_flt;
   } vec_t;

   vec_t vecs[$];

   fetch_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump_valid     (jump_valid),
      .jump_target    (jump_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .pc_src         (pc_src),
      .misalign_fault (misalign_fault)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic bt, logic [31:0] btgt, logic jv, logic [31:0] jtgt,
                               logic rdy, logic rspv, logic [31:0] rspd, logic ir,
                               logic e_req, logic [31:0] e_addr, logic e_iv,
                               logic [31:0] e_idata, logic [31:0] e_ipc,
                               logic [1:0] e_src, logic e_flt);
      vec_t v;
      v.bt = bt; v.btgt = btgt; v.jv = jv; v.jtgt = jtgt;
      v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.ir = ir;
      v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
      v.e_idata = e_idata; v.e_ipc = e_ipc; v.e_src = e_src; v.e_flt = e_flt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      branch_taken = 0; branch_target = 0; jump_valid = 0; jump_target = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; inst_ready = 0;
   endtask

   task automatic apply(input vec_t v);
      branch_taken = v.bt; branch_target = v.btgt; jump_valid = v.jv; jump_target = v.jtgt;
      imem_req_ready = v.rdy; imem_rsp_valid = v.rspv; imem_rsp_data = v.rspd; inst_ready = v.ir;
   endtask

   initial begin
      //          bt btgt  jv jtgt  rdy rspv rspd          ir  req addr     iv idata         ipc    src  flt
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            1,  0, 32'h0,   0, 32'h0,        32'h0,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            1,  1, 32'h0,   0, 32'h0,        32'h0,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 1, 32'hA000_0000,1,  0, 32'h0,   0, 32'h0,        32'h0,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            1,  0, 32'h0,   1, 32'hA000_0000,32'h0,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            1,  1, 32'h4,   0, 32'hA000_0000,32'h0,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 1, 32'hA000_0004,1,  0, 32'h4,   0, 32'hA000_0000,32'h0,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,            1,  0, 32'h4,   1, 32'hA000_0004,32'h4,  0,   0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(0, 0, 0, 0,    0, 0, 0,            1,  1, 32'h8,   0, 32'hA000_0004,32'h4,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            1,  1, 32'h8,   0, 32'hA000_0004,32'h4,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 1, 32'hA000_0008,0,  0, 32'h8,   0, 32'hA000_0004,32'h4,  0,   0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(0, 0, 0, 0,    0, 0, 0,            0,  0, 32'h8,   1, 32'hA000_0008,32'h8,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,            1,  0, 32'h8,   1, 32'hA000_0008,32'h8,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            0,  1, 32'hC,   0, 32'hA000_0008,32'h8,  0,   0));
      vecs.push_back(mk(1, 32'h40, 0, 0,  0, 0, 0,            0,  0, 32'hC,   0, 32'hA000_0008,32'h8,  1,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 1, 32'hDEAD_BEEF,0,  0, 32'h40,  0, 32'hA000_0008,32'h8,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            0,  1, 32'h40,  0, 32'hA000_0008,32'h8,  0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 1, 32'hB000_0040,0,  0, 32'h40,  0, 32'hA000_0008,32'h8,  0,   0));
      vecs.push_back(mk(1, 32'h40, 1, 32'h80, 0, 0, 0,        0,  0, 32'h40,  1, 32'hB000_0040,32'h40, 2,   0));
      vecs.push_back(mk(0, 0,    0, 0,    1, 0, 0,            0,  1, 32'h80,  0, 32'hB000_0040,32'h40, 0,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 1, 32'hC000_0080,0,  0, 32'h80,  0, 32'hB000_0040,32'h40, 0,   0));
      vecs.push_back(mk(1, 32'h42, 0, 0,  0, 0, 0,            1,  0, 32'h80,  1, 32'hC000_0080,32'h80, 1,   0));
      vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,            0,  1, EXP_MIS, 0, 32'hC000_0080,32'h80, 0,   EXP_FLT));
      vecs.push_back(mk(0, 0,    0, 0,    0, 0, 0,            0,  1, EXP_MIS, 0, 32'hC000_0080,32'h80, 0,   0));

      idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset req_valid", {31'b0, imem_req_valid}, 32'h0);
      chk("reset imem_addr", imem_addr, 32'h0);
      chk("reset inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("reset inst_data", inst_data, 32'h0);
      chk("reset inst_pc", inst_pc, 32'h0);
      chk("reset pc_src", {30'b0, pc_src}, 32'h0);
      chk("reset misalign_fault", {31'b0, misalign_fault}, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         #1;
         chk($sformatf("v%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_req});
         chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
         chk($sformatf("v%0d inst_data", i), inst_data, vecs[i].e_idata);
         chk($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
         chk($sformatf("v%0d pc_src", i), {30'b0, pc_src}, {30'b0, vecs[i].e_src});
         chk($sformatf("v%0d misalign_fault", i), {31'b0, misalign_fault}, {31'b0, vecs[i].e_flt});
         @(negedge clk);
      end

      // PC wrap: jump to the last word, fetch it, advance to address 0
      idle();
      jump_valid = 1; jump_target = 32'hFFFF_FFFC;
      #1 chk("wrap jump pc_src", {30'b0, pc_src}, 32'h2);
      @(negedge clk);
      idle(); imem_req_ready = 1;
      #1 chk("wrap req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      idle(); imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678;
      @(negedge clk);
      idle(); inst_ready = 1;
      #1 chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
      chk("wrap inst_data", inst_data, 32'h1234_5678);
      @(negedge clk);
      idle(); imem_req_ready = 1;
      #1 chk("wrap next addr", imem_addr, 32'h0);
      chk("wrap next req_valid", {31'b0, imem_req_valid}, 32'h1);
      @(negedge clk);

      // reset while an instruction is held, then a late response during the boot cycle
      idle(); imem_rsp_valid = 1; imem_rsp_data = 32'h5555_AAAA;
      @(negedge clk);
      idle();
      #1 chk("held inst_valid", {31'b0, inst_valid}, 32'h1);
      chk("held inst_data", inst_data, 32'h5555_AAAA);
      rst_n = 1'b0;
      #1 chk("async reset inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("async reset inst_data", inst_data, 32'h0);
      chk("async reset req_valid", {31'b0, imem_req_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rsp_valid = 1; imem_rsp_data = 32'h7777_7777; imem_req_ready = 0;
      #1 chk("boot req_valid", {31'b0, imem_req_valid}, 32'h0);
      @(negedge clk);
      idle();
      #1 chk("late rsp inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("late rsp inst_data", inst_data, 32'h0);
      chk("post boot req_valid", {31'b0, imem_req_valid}, 32'h1);
      chk("post boot addr", imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
